// File: rtl/apb_req_arbiter.sv
// ---------------------------------------------------------------------------
// apb_req_arbiter
//
// Shares the user-side command port of a single APB master among NUM_REQ
// independent requesters. The arbiter picks one pending request in
// round-robin order and latches it. It then drives transfer/READ_WRITE/
// address/data to the master for a fixed window of XFER_CYCLES cycles.
// At the end of the window it samples the master's response and hands it
// back to the winner together with a one-cycle done pulse.
//
// Ports:
//   PCLK, PRESETn        clock (posedge) and asynchronous active-low reset
//   req, req_rw          per-requester request level and direction (1=write)
//   req_addr, req_wdata  packed per-requester address / write data,
//                        requester i at [i*W +: W]
//   gnt                  one-hot grant, held through XFER and RESP
//   done                 one-hot single-cycle completion pulse
//   rsp_rdata, rsp_err   response data / slave error, valid while done=1
//   busy                 high while a transaction is in progress
//   transfer, READ_WRITE,
//   apb_write_paddr, apb_read_paddr,
//   apb_write_data       command outputs to the APB master
//   PSLVERR,
//   apb_read_data_out    response inputs from the APB master
// ---------------------------------------------------------------------------
module apb_req_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ADDR_W      = 9,
    parameter int DATA_W      = 8,
    parameter int XFER_CYCLES = 3
) (
    input  logic                        PCLK,
    input  logic                        PRESETn,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ-1:0]          req_rw,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]          gnt,
    output logic [NUM_REQ-1:0]          done,
    output logic [DATA_W-1:0]           rsp_rdata,
    output logic                        rsp_err,
    output logic                        busy,
    output logic                        transfer,
    output logic                        READ_WRITE,
    output logic [ADDR_W-1:0]           apb_write_paddr,
    output logic [ADDR_W-1:0]           apb_read_paddr,
    output logic [DATA_W-1:0]           apb_write_data,
    input  logic                        PSLVERR,
    input  logic [DATA_W-1:0]           apb_read_data_out
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(XFER_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XFER_CYCLES - 1);
    localparam logic [PTR_W-1:0] PTR_MAX  = PTR_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [PTR_W-1:0]   ptr, ptr_nxt;
    logic [PTR_W-1:0]   win, win_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;

    logic [NUM_REQ-1:0] gnt_nxt, done_nxt;
    logic [DATA_W-1:0]  rsp_rdata_nxt;
    logic               rsp_err_nxt, busy_nxt, transfer_nxt, rw_nxt;
    logic [ADDR_W-1:0]  wpaddr_nxt, rpaddr_nxt;
    logic [DATA_W-1:0]  wdata_nxt;

    logic               arb_found;
    logic [PTR_W-1:0]   arb_idx;
    logic [PTR_W:0]     arb_sum;

    // Round-robin search: walk the requesters starting at ptr and wrap
    // modulo NUM_REQ. The first one found with req set wins. The extra
    // bit in arb_sum lets the wrap work for non-power-of-two NUM_REQ.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        arb_sum   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            arb_sum = {1'b0, ptr} + (PTR_W + 1)'(i);
            if (arb_sum >= (PTR_W + 1)'(NUM_REQ)) begin
                arb_sum = arb_sum - (PTR_W + 1)'(NUM_REQ);
            end
            if (!arb_found && req[arb_sum[PTR_W-1:0]]) begin
                arb_found = 1'b1;
                arb_idx   = arb_sum[PTR_W-1:0];
            end
        end
    end

    // Next-state and next-output logic. The registered master-side outputs
    // double as the latched copy of the winning request. Holding them
    // through XFER is what makes later req_* changes invisible to the
    // master.
    always_comb begin
        state_nxt     = state;
        ptr_nxt       = ptr;
        win_nxt       = win;
        cnt_nxt       = cnt;
        gnt_nxt       = gnt;
        done_nxt      = done;
        rsp_rdata_nxt = rsp_rdata;
        rsp_err_nxt   = rsp_err;
        busy_nxt      = busy;
        transfer_nxt  = transfer;
        rw_nxt        = READ_WRITE;
        wpaddr_nxt    = apb_write_paddr;
        rpaddr_nxt    = apb_read_paddr;
        wdata_nxt     = apb_write_data;

        unique case (state)
            IDLE: begin
                if (arb_found) begin
                    state_nxt    = XFER;
                    win_nxt      = arb_idx;
                    cnt_nxt      = '0;
                    gnt_nxt      = {{(NUM_REQ-1){1'b0}}, 1'b1} << arb_idx;
                    busy_nxt     = 1'b1;
                    transfer_nxt = 1'b1;
                    rw_nxt       = req_rw[arb_idx];
                    // Only the address/data path matching the direction is
                    // populated; the other one is driven to zero.
                    if (req_rw[arb_idx]) begin
                        wpaddr_nxt = req_addr[arb_idx*ADDR_W +: ADDR_W];
                        wdata_nxt  = req_wdata[arb_idx*DATA_W +: DATA_W];
                        rpaddr_nxt = '0;
                    end else begin
                        wpaddr_nxt = '0;
                        wdata_nxt  = '0;
                        rpaddr_nxt = req_addr[arb_idx*ADDR_W +: ADDR_W];
                    end
                end
            end

            XFER: begin
                cnt_nxt = cnt + CNT_W'(1);
                if (cnt == CNT_LAST) begin
                    // Last cycle of the access window: capture the
                    // master's response. Writes return zero data.
                    state_nxt     = RESP;
                    transfer_nxt  = 1'b0;
                    done_nxt      = gnt;
                    rsp_err_nxt   = PSLVERR;
                    rsp_rdata_nxt = READ_WRITE ? '0 : apb_read_data_out;
                end
            end

            RESP: begin
                // No arbitration here; a request seen now is handled in
                // the following IDLE cycle with the pointer already moved.
                state_nxt     = IDLE;
                ptr_nxt       = (win == PTR_MAX) ? '0 : win + PTR_W'(1);
                gnt_nxt       = '0;
                done_nxt      = '0;
                rsp_rdata_nxt = '0;
                rsp_err_nxt   = 1'b0;
                busy_nxt      = 1'b0;
                rw_nxt        = 1'b0;
                wpaddr_nxt    = '0;
                rpaddr_nxt    = '0;
                wdata_nxt     = '0;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers. An asynchronous reset drops any
    // in-flight transaction immediately, so no done pulse is issued.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state           <= IDLE;
            ptr             <= '0;
            win             <= '0;
            cnt             <= '0;
            gnt             <= '0;
            done            <= '0;
            rsp_rdata       <= '0;
            rsp_err         <= 1'b0;
            busy            <= 1'b0;
            transfer        <= 1'b0;
            READ_WRITE      <= 1'b0;
            apb_write_paddr <= '0;
            apb_read_paddr  <= '0;
            apb_write_data  <= '0;
        end else begin
            state           <= state_nxt;
            ptr             <= ptr_nxt;
            win             <= win_nxt;
            cnt             <= cnt_nxt;
            gnt             <= gnt_nxt;
            done            <= done_nxt;
            rsp_rdata       <= rsp_rdata_nxt;
            rsp_err         <= rsp_err_nxt;
            busy            <= busy_nxt;
            transfer        <= transfer_nxt;
            READ_WRITE      <= rw_nxt;
            apb_write_paddr <= wpaddr_nxt;
            apb_read_paddr  <= rpaddr_nxt;
            apb_write_data  <= wdata_nxt;
        end
    end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// ---------------------------------------------------------------------------
// tb_apb_req_arbiter
//
// Directed testbench for apb_req_arbiter (NUM_REQ=4, ADDR_W=9, DATA_W=8,
// XFER_CYCLES=3). Stimulus pushes the expected response of each
// transaction onto a scoreboard queue. A monitor pops an entry whenever
// done pulses and checks the winner and response against it. The main
// sequence also checks grant order, transfer length, master-side routing
// and reset behaviour.
// ---------------------------------------------------------------------------
module tb_apb_req_arbiter;

    localparam int NUM_REQ     = 4;
    localparam int ADDR_W      = 9;
    localparam int DATA_W      = 8;
    localparam int XFER_CYCLES = 3;

    logic                      PCLK;
    logic                      PRESETn;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        req_rw;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        done;
    logic [DATA_W-1:0]         rsp_rdata;
    logic                      rsp_err;
    logic                      busy;
    logic                      transfer;
    logic                      READ_WRITE;
    logic [ADDR_W-1:0]         apb_write_paddr;
    logic [ADDR_W-1:0]         apb_read_paddr;
    logic [DATA_W-1:0]         apb_write_data;
    logic                      PSLVERR;
    logic [DATA_W-1:0]         apb_read_data_out;

    typedef struct {
        int               idx;
        logic [DATA_W-1:0] rdata;
        logic             err;
    } exp_t;

    exp_t              sb[$];
    exp_t              mon_e;
    logic [ADDR_W-1:0] tb_addr  [NUM_REQ];
    logic [DATA_W-1:0] tb_wdata [NUM_REQ];
    int                n_asserts = 0;
    int                n_fail    = 0;
    int                cycle     = 0;
    int                g_prev;
    int                g_now;

    apb_req_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .XFER_CYCLES(XFER_CYCLES)
    ) dut (
        .PCLK             (PCLK),
        .PRESETn          (PRESETn),
        .req              (req),
        .req_rw           (req_rw),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .gnt              (gnt),
        .done             (done),
        .rsp_rdata        (rsp_rdata),
        .rsp_err          (rsp_err),
        .busy             (busy),
        .transfer         (transfer),
        .READ_WRITE       (READ_WRITE),
        .apb_write_paddr  (apb_write_paddr),
        .apb_read_paddr   (apb_read_paddr),
        .apb_write_data   (apb_write_data),
        .PSLVERR          (PSLVERR),
        .apb_read_data_out(apb_read_data_out)
    );

    // Free-running clock plus a cycle count used to measure grant spacing.
    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;
    always @(posedge PCLK) cycle++;

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives the request vectors and packs the per-requester address and
    // data tables onto the flat buses.
    task automatic applyStimulus(input logic [NUM_REQ-1:0] r,
                                 input logic [NUM_REQ-1:0] rw);
        req    = r;
        req_rw = rw;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_addr[i*ADDR_W +: ADDR_W]  = tb_addr[i];
            req_wdata[i*DATA_W +: DATA_W] = tb_wdata[i];
        end
    endtask

    // Follows one transaction from grant to its return to IDLE. Requests
    // are replaced by req_after once the grant has been seen.
    task automatic doXfer(input int idx, input logic [NUM_REQ-1:0] req_after,
                          output int gcycle);
        int                 waited;
        int                 xcnt;
        logic [NUM_REQ-1:0] onehot;
        logic               rw;
        onehot = 4'b0001 << idx;
        rw     = req_rw[idx];
        waited = 0;
        while (gnt === 4'b0000 && waited < 40) begin
            @(negedge PCLK);
            waited++;
        end
        checkOutput("grant_in_time", 32'(waited < 40), 32'd1);
        gcycle = cycle;
        checkOutput("gnt_winner", 32'(gnt), 32'(onehot));
        applyStimulus(req_after, req_rw);
        xcnt = 0;
        while (transfer === 1'b1 && xcnt < 10) begin
            checkOutput("xfer_gnt", 32'(gnt), 32'(onehot));
            checkOutput("xfer_busy", 32'(busy), 32'd1);
            checkOutput("xfer_rw", 32'(READ_WRITE), 32'(rw));
            checkOutput("xfer_wpaddr", 32'(apb_write_paddr), rw ? 32'(tb_addr[idx]) : 32'd0);
            checkOutput("xfer_rpaddr", 32'(apb_read_paddr), rw ? 32'd0 : 32'(tb_addr[idx]));
            checkOutput("xfer_wdata", 32'(apb_write_data), rw ? 32'(tb_wdata[idx]) : 32'd0);
            xcnt++;
            @(negedge PCLK);
        end
        checkOutput("xfer_len", 32'(xcnt), 32'(XFER_CYCLES));
        checkOutput("resp_gnt", 32'(gnt), 32'(onehot));
        checkOutput("resp_done", 32'(done), 32'(onehot));
        checkOutput("resp_busy", 32'(busy), 32'd1);
        @(negedge PCLK);
        checkOutput("idle_gnt", 32'(gnt), 32'd0);
        checkOutput("idle_done", 32'(done), 32'd0);
        checkOutput("idle_busy", 32'(busy), 32'd0);
        checkOutput("idle_rdata", 32'(rsp_rdata), 32'd0);
        checkOutput("idle_err", 32'(rsp_err), 32'd0);
        checkOutput("idle_wpaddr", 32'(apb_write_paddr), 32'd0);
    endtask

    // Scoreboard monitor: every done pulse must match the oldest expected
    // response.
    always @(negedge PCLK) begin
        if (PRESETn === 1'b1 && done !== 4'b0000) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_done", 32'(done), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                checkOutput("sb_done", 32'(done), 32'(4'b0001 << mon_e.idx));
                checkOutput("sb_rdata", 32'(rsp_rdata), 32'(mon_e.rdata));
                checkOutput("sb_err", 32'(rsp_err), 32'(mon_e.err));
            end
        end
    end

    initial begin
        PRESETn           = 1'b0;
        PSLVERR           = 1'b0;
        apb_read_data_out = 8'h00;
        req_addr          = '0;
        req_wdata         = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            tb_addr[i]  = 9'h100 + 9'(i * 3);
            tb_wdata[i] = 8'h10 + 8'(i);
        end
        applyStimulus(4'b0000, 4'b0000);
        #1;
        checkOutput("rst_gnt", 32'(gnt), 32'd0);
        checkOutput("rst_transfer", 32'(transfer), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_rw", 32'(READ_WRITE), 32'd0);
        @(negedge PCLK);
        PRESETn = 1'b1;
        @(negedge PCLK);
        checkOutput("idle_noreq_transfer", 32'(transfer), 32'd0);

        $display("[TB] single write from requester 0");
        tb_addr[0]  = 9'h005;
        tb_wdata[0] = 8'hA5;
        sb.push_back('{idx: 0, rdata: 8'h00, err: 1'b0});
        applyStimulus(4'b0001, 4'b0001);
        doXfer(0, 4'b0000, g_now);

        $display("[TB] single read from requester 2");
        tb_addr[2]        = 9'h1F0;
        apb_read_data_out = 8'h3C;
        sb.push_back('{idx: 2, rdata: 8'h3C, err: 1'b0});
        applyStimulus(4'b0100, 4'b0000);
        doXfer(2, 4'b0000, g_now);

        $display("[TB] pointer wrap with req=0011");
        tb_addr[0] = 9'h021;
        tb_addr[1] = 9'h042;
        sb.push_back('{idx: 0, rdata: 8'h00, err: 1'b0});
        sb.push_back('{idx: 1, rdata: 8'h3C, err: 1'b0});
        applyStimulus(4'b0011, 4'b0001);
        doXfer(0, 4'b0011, g_prev);
        doXfer(1, 4'b0000, g_now);
        checkOutput("wrap_spacing", 32'(g_now - g_prev), 32'(XFER_CYCLES + 2));

        $display("[TB] read with slave error, then clean read");
        tb_addr[3]        = 9'h0AA;
        apb_read_data_out = 8'h77;
        PSLVERR           = 1'b1;
        sb.push_back('{idx: 3, rdata: 8'h77, err: 1'b1});
        applyStimulus(4'b1000, 4'b0000);
        doXfer(3, 4'b0000, g_now);
        PSLVERR           = 1'b0;
        apb_read_data_out = 8'h66;
        sb.push_back('{idx: 3, rdata: 8'h66, err: 1'b0});
        applyStimulus(4'b1000, 4'b0000);
        doXfer(3, 4'b0000, g_now);

        $display("[TB] all four requesting from reset");
        PRESETn           = 1'b0;
        apb_read_data_out = 8'h5A;
        applyStimulus(4'b1111, 4'b0101);
        sb.push_back('{idx: 0, rdata: 8'h00, err: 1'b0});
        sb.push_back('{idx: 1, rdata: 8'h5A, err: 1'b0});
        sb.push_back('{idx: 2, rdata: 8'h00, err: 1'b0});
        sb.push_back('{idx: 3, rdata: 8'h5A, err: 1'b0});
        sb.push_back('{idx: 0, rdata: 8'h00, err: 1'b0});
        @(negedge PCLK);
        PRESETn = 1'b1;
        doXfer(0, 4'b1111, g_prev);
        for (int k = 1; k < 5; k++) begin
            doXfer(k % NUM_REQ, (k == 4) ? 4'b0000 : 4'b1111, g_now);
            checkOutput("rr_spacing", 32'(g_now - g_prev), 32'(XFER_CYCLES + 2));
            g_prev = g_now;
        end

        $display("[TB] reset during second XFER cycle");
        applyStimulus(4'b0100, 4'b0000);
        for (int w = 0; w < 40 && gnt === 4'b0000; w++) @(negedge PCLK);
        checkOutput("abort_gnt", 32'(gnt), 32'b0100);
        applyStimulus(4'b0000, 4'b0000);
        @(negedge PCLK);
        checkOutput("abort_xfer2", 32'(transfer), 32'd1);
        #2;
        PRESETn = 1'b0;
        #1;
        checkOutput("abort_transfer", 32'(transfer), 32'd0);
        checkOutput("abort_gnt_clr", 32'(gnt), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge PCLK);
        checkOutput("abort_done", 32'(done), 32'd0);
        PRESETn = 1'b1;
        @(negedge PCLK);
        checkOutput("abort_no_done", 32'(done), 32'd0);
        sb.push_back('{idx: 0, rdata: 8'h00, err: 1'b0});
        applyStimulus(4'b1001, 4'b0001);
        doXfer(0, 4'b0000, g_now);
        sb.push_back('{idx: 2, rdata: 8'h00, err: 1'b0});
        applyStimulus(4'b0100, 4'b0100);
        doXfer(2, 4'b0000, g_now);

        repeat (2) @(negedge PCLK);
        checkOutput("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_req_arbiter.md
Name: apb_req_arbiter

Overview:
- Shares the single user-side command port of the APB master among NUM_REQ independent requesters, using round-robin arbitration.
- Latches the winning request and drives transfer, READ_WRITE, address and data to the master for a fixed access window.
- Samples PSLVERR and apb_read_data_out at the end of the window and returns them to the winner with a one-cycle done pulse.
- Sits between the requesting agents and the APB master, in the same PCLK domain.

Parameters:
- NUM_REQ, 4: number of requesters; legal range 2..8.
- ADDR_W, 9: APB address width.
- DATA_W, 8: APB data width.
- XFER_CYCLES, 3: cycles that transfer is held high per transaction; minimum 2, covering the master's SETUP and ACCESS phases.

Ports:
- PCLK  in  1  clock; all logic on posedge.
- PRESETn  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester request level.
- req_rw  in  NUM_REQ  per-requester direction; 1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i occupies [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*DATA_W  packed write data, same packing.
- gnt  out  NUM_REQ  one-hot; held for the whole transaction (XFER and RESP states).
- done  out  NUM_REQ  one-hot; single-cycle completion pulse to the winner.
- rsp_rdata  out  DATA_W  read data; valid only while done is high.
- rsp_err  out  1  slave error; valid only while done is high.
- busy  out  1  high in XFER and RESP.
- transfer  out  1  to master: transaction active.
- READ_WRITE  out  1  to master: direction.
- apb_write_paddr  out  ADDR_W  to master: write address.
- apb_read_paddr  out  ADDR_W  to master: read address.
- apb_write_data  out  DATA_W  to master: write data.
- PSLVERR  in  1  from master: slave error.
- apb_read_data_out  in  DATA_W  from master: read data.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-transaction):
  - All outputs go to 0.
  - FSM goes to IDLE; RR pointer goes to 0; transaction counter goes to 0.
  - Any in-flight transaction is dropped with no done pulse.
- Every output is registered. No X may appear on any master-side output while transfer=1.
- FSM states: IDLE, XFER, RESP.
- IDLE:
  - If req != 0, select the first set bit searching from index ptr upward, wrapping modulo NUM_REQ.
  - On that posedge: latch the winner's rw/addr/wdata, set gnt[w], set transfer=1, go to XFER, counter=0.
  - If req == 0, stay in IDLE with all outputs 0.
- XFER:
  - transfer=1 and master outputs are held constant from the latched copy.
  - Later changes on req_* inputs, including req[w] deasserting, are ignored and the transaction completes.
  - Counter increments every cycle. When counter == XFER_CYCLES-1: sample PSLVERR and apb_read_data_out into rsp_err and rsp_rdata, set done[w]=1, transfer=0, go to RESP.
  - Result: transfer is high for exactly XFER_CYCLES cycles.
- RESP:
  - done[w] is high for this one cycle only; gnt[w] stays high.
  - On exit: clear gnt, done, rsp_rdata and rsp_err; set ptr = (w+1) mod NUM_REQ; go to IDLE.
  - RESP never arbitrates, so each transaction occupies XFER_CYCLES+2 cycles including the IDLE cycle.
- Address and data routing:
  - Write: apb_write_paddr = addr, apb_write_data = wdata, apb_read_paddr = 0, READ_WRITE = 1.
  - Read: apb_read_paddr = addr, apb_write_paddr = 0, apb_write_data = 0, READ_WRITE = 0.
- Response content:
  - Writes report rsp_rdata = 0.
  - rsp_err reports PSLVERR for both reads and writes.
- Fairness:
  - A requester that holds req high is granted within (NUM_REQ-1)*(XFER_CYCLES+2)+1 cycles.
  - A requester that re-requests immediately after its own done gets lowest priority.
- Pointer wrap: after requester NUM_REQ-1 wins, ptr=0.
- Simultaneous new request and done: a request arriving in the RESP cycle is considered in the next IDLE cycle.

Test Plan:
- Reset, then req[0]=1, rw=1, addr=9'h05, wdata=8'hA5 → transfer high for 3 cycles with apb_write_paddr=05, apb_write_data=A5, apb_read_paddr=0, READ_WRITE=1; done[0] pulses 1 cycle with rsp_rdata=0, rsp_err=0.
- req[2] read of addr 9'h1F0, master returns apb_read_data_out=8'h3C with PSLVERR=0 → READ_WRITE=0, apb_read_paddr=1F0, apb_write_paddr=0; done[2] pulse with rsp_rdata=3C.
- req=4'b1111 held continuously from reset → grant order 0,1,2,3,0; transaction starts 5 cycles apart; each done precedes the next gnt.
- ptr=3 after serving requester 2, then req=4'b0011 → requester 0 granted (wrap), then requester 1.
- Read with PSLVERR=1 at the sampling cycle → rsp_err=1 in the done cycle; the next transaction shows rsp_err=0.
- PRESETn low during the 2nd XFER cycle → transfer, gnt and busy drop to 0 without waiting for a clock edge; no done pulse; after release, req=4'b0100 is granted first with ptr restarting at 0.
